// File: rtl/cmplx_mult_acc_pkg.sv
// Shared width derivations and the round/scale/saturate arithmetic used by the
// complex multiply-accumulate datapath.
package cmplx_pkg;

    localparam int SAT_W = 128;

    typedef logic signed [SAT_W-1:0] wide_t;

    typedef struct packed {
        wide_t val;
        logic  sat;
    } sat_res_t;

    function automatic int prod_w(input int dw_a, input int dw_b);
        return dw_a + dw_b + 1;
    endfunction

    function automatic int sum_w(input int dw_a, input int dw_b);
        return dw_a + dw_b + 2;
    endfunction

    function automatic int acc_w(input int dw_a, input int dw_b, input int len_w);
        return sum_w(dw_a, dw_b) + len_w;
    endfunction

    // Round half up, arithmetic shift right, then clamp to a signed out_w range.
    function automatic sat_res_t sat_round(input wide_t x, input int scale, input int out_w);
        wide_t    one;
        wide_t    r;
        wide_t    hi;
        wide_t    lo;
        sat_res_t res;
        one = wide_t'(1);
        r   = x;
        if (scale > 0) begin
            r = (x + (one <<< (scale - 1))) >>> scale;
        end
        hi = (one <<< (out_w - 1)) - one;
        lo = -(one <<< (out_w - 1));
        res.sat = 1'b0;
        res.val = r;
        if (r > hi) begin
            res.val = hi;
            res.sat = 1'b1;
        end else if (r < lo) begin
            res.val = lo;
            res.sat = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/cmplx_mult_acc_if.sv
// Sample-in / result-out stream bundle of the complex multiply-accumulate.
// slave is the block's view, master the view of the surrounding logic.
interface cmplx_mult_acc_if #(
    parameter int DW_A      = 16,
    parameter int DW_B      = 16,
    parameter int DW_O      = 32,
    parameter int ACC_LEN_W = 8
);
    logic                   ivalid;
    logic                   iready;
    logic signed [DW_A-1:0] dataa_r;
    logic signed [DW_A-1:0] dataa_i;
    logic signed [DW_B-1:0] datab_r;
    logic signed [DW_B-1:0] datab_i;
    logic                   conj_b;
    logic [ACC_LEN_W-1:0]   acc_len;
    logic                   ovalid;
    logic                   oready;
    logic signed [DW_O-1:0] result_r;
    logic signed [DW_O-1:0] result_i;
    logic                   sat;

    modport slave (
        input  ivalid, dataa_r, dataa_i, datab_r, datab_i, conj_b, acc_len, oready,
        output iready, ovalid, result_r, result_i, sat
    );

    modport master (
        output ivalid, dataa_r, dataa_i, datab_r, datab_i, conj_b, acc_len, oready,
        input  iready, ovalid, result_r, result_i, sat
    );
endinterface

// File: rtl/cmplx_sat_round.sv
// One component of the output stage: round, shift and clamp an accumulator value.
module cmplx_sat_round
    import cmplx_pkg::*;
#(
    parameter int IN_W  = 42,
    parameter int OUT_W = 32,
    parameter int SCALE = 0
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout,
    output logic                    sat
);
    sat_res_t res;
    logic     unused_hi;

    always_comb begin
        res  = sat_round({{(SAT_W-IN_W){din[IN_W-1]}}, din}, SCALE, OUT_W);
        dout = res.val[OUT_W-1:0];
        sat  = res.sat;
    end

    // After clamping the upper bits are pure sign extension.
    assign unused_hi = ^res.val[SAT_W-1:OUT_W];

endmodule

// File: rtl/cmplx_mult_acc.sv
// Pipelined complex multiply-accumulate: optional conj(B), frame accumulation,
// rounded/saturated output, global stall on output backpressure.
module cmplx_mult_acc
    import cmplx_pkg::*;
#(
    parameter int DW_A      = 16,
    parameter int DW_B      = 16,
    parameter int DW_O      = 32,
    parameter int ACC_LEN_W = 8,
    parameter int SCALE     = 0
) (
    input logic             clock,
    input logic             reset,
    cmplx_mult_acc_if.slave bus
);
    localparam int BI_W   = DW_B + 1;
    localparam int PROD_W = prod_w(DW_A, DW_B);
    localparam int SUM_W  = sum_w(DW_A, DW_B);
    localparam int ACC_W  = acc_w(DW_A, DW_B, ACC_LEN_W);

    logic                     rst_q, adv, xfer;
    logic [ACC_LEN_W-1:0]     frm_cnt, frm_len, len_eff;
    logic                     last_in;
    logic signed [DW_A-1:0]   s1_ar, s1_ai;
    logic signed [DW_B-1:0]   s1_br;
    logic signed [BI_W-1:0]   s1_bi;
    logic signed [PROD_W-1:0] s2_rr, s2_ii, s2_ri, s2_ir;
    logic signed [SUM_W-1:0]  s3_re, s3_im;
    logic signed [ACC_W-1:0]  acc_r, acc_i;
    logic                     v1, v2, v3, l1, l2, l3, acc_open, done4;
    logic signed [DW_O-1:0]   rnd_r, rnd_i;
    logic                     sat_r, sat_i;

    // NOTE: every clocked assignment uses <= so all stages sample pre-edge values.
    always_ff @(posedge clock) rst_q <= reset;

    assign adv       = ~bus.ovalid | bus.oready;
    assign bus.iready = adv & rst_q;
    assign xfer      = bus.ivalid & bus.iready;

    // NOTE: combinational outputs get a default first so no path infers a latch.
    always_comb begin
        len_eff = frm_len;
        if (frm_cnt == '0) begin
            len_eff = (bus.acc_len == '0) ? ACC_LEN_W'(1) : bus.acc_len;
        end
        last_in = (frm_cnt == len_eff - ACC_LEN_W'(1));
    end

    // NOTE: datapath registers carry no reset; the valid bits alone qualify them.
    always_ff @(posedge clock) begin
        if (adv) begin
            s1_ar <= bus.dataa_r;
            s1_ai <= bus.dataa_i;
            s1_br <= bus.datab_r;
            s1_bi <= bus.conj_b ? -BI_W'(bus.datab_i) : BI_W'(bus.datab_i);
            s2_rr <= PROD_W'(s1_ar) * PROD_W'(s1_br);
            s2_ii <= PROD_W'(s1_ai) * PROD_W'(s1_bi);
            s2_ri <= PROD_W'(s1_ar) * PROD_W'(s1_bi);
            s2_ir <= PROD_W'(s1_ai) * PROD_W'(s1_br);
            s3_re <= SUM_W'(s2_rr) - SUM_W'(s2_ii);
            s3_im <= SUM_W'(s2_ri) + SUM_W'(s2_ir);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            frm_cnt      <= '0;
            frm_len      <= '0;
            {v1, v2, v3} <= '0;
            {l1, l2, l3} <= '0;
            acc_open     <= 1'b0;
            done4        <= 1'b0;
            acc_r        <= '0;
            acc_i        <= '0;
            bus.ovalid   <= 1'b0;
            bus.result_r <= '0;
            bus.result_i <= '0;
            bus.sat      <= 1'b0;
        end else if (adv) begin
            if (xfer) begin
                frm_cnt <= last_in ? '0 : frm_cnt + ACC_LEN_W'(1);
                frm_len <= len_eff;
            end
            v1 <= xfer;
            l1 <= last_in;
            v2 <= v1;
            l2 <= l1;
            v3 <= v2;
            l3 <= l2;
            // A closed frame makes the next sample reload the accumulator directly.
            if (v3) begin
                acc_r    <= (acc_open ? acc_r : '0) + ACC_W'(s3_re);
                acc_i    <= (acc_open ? acc_i : '0) + ACC_W'(s3_im);
                acc_open <= ~l3;
            end
            done4      <= v3 & l3;
            bus.ovalid <= done4;
            if (done4) begin
                bus.result_r <= rnd_r;
                bus.result_i <= rnd_i;
                bus.sat      <= sat_r | sat_i;
            end
        end
    end

    cmplx_sat_round #(.IN_W(ACC_W), .OUT_W(DW_O), .SCALE(SCALE)) u_sr_r (
        .din  (acc_r),
        .dout (rnd_r),
        .sat  (sat_r)
    );

    cmplx_sat_round #(.IN_W(ACC_W), .OUT_W(DW_O), .SCALE(SCALE)) u_sr_i (
        .din  (acc_i),
        .dout (rnd_i),
        .sat  (sat_i)
    );

endmodule

// File: tb/tb_cmplx_mult_acc.sv
// Self-checking bench: two instances (SCALE 0 and 2) share stimulus; a frame-level
// model predicts every result, and a per-cycle monitor checks handshake rules.
module tb_cmplx_mult_acc;
    localparam int DW_A = 16;
    localparam int DW_B = 16;
    localparam int DW_O = 32;
    localparam int LW   = 8;
    localparam longint MAXO = 64'sd2147483647;
    localparam longint MINO = -64'sd2147483648;

    typedef struct {
        longint r0, i0, r2, i2;
        bit     s0, s2;
    } exp_t;

    logic   clock = 1'b0;
    logic   reset;
    int     cyc = 0;
    logic   rst_prev = 1'b0;
    int     n_checks = 0;
    int     n_fail = 0;
    int     n_out = 0;
    exp_t   exp_q[$];
    longint m_sum_r, m_sum_i;
    int     m_cnt = 0;
    int     m_len = 1;
    bit     hold_prev = 0;
    longint prev_r, prev_i, prev_s;
    bit     rnd_done;

    cmplx_mult_acc_if #(.DW_A(DW_A), .DW_B(DW_B), .DW_O(DW_O), .ACC_LEN_W(LW)) bus0 ();
    cmplx_mult_acc_if #(.DW_A(DW_A), .DW_B(DW_B), .DW_O(DW_O), .ACC_LEN_W(LW)) bus1 ();

    assign bus1.ivalid  = bus0.ivalid;
    assign bus1.dataa_r = bus0.dataa_r;
    assign bus1.dataa_i = bus0.dataa_i;
    assign bus1.datab_r = bus0.datab_r;
    assign bus1.datab_i = bus0.datab_i;
    assign bus1.conj_b  = bus0.conj_b;
    assign bus1.acc_len = bus0.acc_len;
    assign bus1.oready  = bus0.oready;

    cmplx_mult_acc #(.DW_A(DW_A), .DW_B(DW_B), .DW_O(DW_O), .ACC_LEN_W(LW), .SCALE(0)) dut0 (
        .clock (clock),
        .reset (reset),
        .bus   (bus0)
    );

    cmplx_mult_acc #(.DW_A(DW_A), .DW_B(DW_B), .DW_O(DW_O), .ACC_LEN_W(LW), .SCALE(2)) dut1 (
        .clock (clock),
        .reset (reset),
        .bus   (bus1)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        cyc      <= cyc + 1;
        rst_prev <= reset;
    end

    task automatic check(input string name, input longint act, input longint req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic void sat_scale(input longint v, input int sh, output longint o, output bit s);
        longint t;
        t = v;
        if (sh > 0) t = (v + (longint'(1) <<< (sh - 1))) >>> sh;
        s = 0;
        if (t > MAXO) begin
            t = MAXO;
            s = 1;
        end else if (t < MINO) begin
            t = MINO;
            s = 1;
        end
        o = t;
    endfunction

    function automatic void model_push(input longint ar, input longint ai, input longint br,
                                       input longint bi, input bit conj, input int len);
        longint bi_e, pr, pi;
        bit     a, b, c, d;
        exp_t   e;
        bi_e = conj ? -bi : bi;
        pr   = ar * br - ai * bi_e;
        pi   = ar * bi_e + ai * br;
        if (m_cnt == 0) begin
            m_len   = (len == 0) ? 1 : len;
            m_sum_r = 0;
            m_sum_i = 0;
        end
        m_sum_r += pr;
        m_sum_i += pi;
        m_cnt++;
        if (m_cnt == m_len) begin
            sat_scale(m_sum_r, 0, e.r0, a);
            sat_scale(m_sum_i, 0, e.i0, b);
            sat_scale(m_sum_r, 2, e.r2, c);
            sat_scale(m_sum_i, 2, e.i2, d);
            e.s0 = a | b;
            e.s2 = c | d;
            exp_q.push_back(e);
            m_cnt = 0;
        end
    endfunction

    // Per-cycle monitor: reset state, iready rule, hold while stalled, in-order results.
    always @(negedge clock) begin
        exp_t e;
        if (cyc > 0) begin
            if (!rst_prev) begin
                check("rst_ovalid", bus0.ovalid, 0);
                check("rst_result_r", bus0.result_r, 0);
                check("rst_result_i", bus0.result_i, 0);
                check("rst_sat", bus0.sat, 0);
                check("rst_iready", bus0.iready, 0);
                exp_q.delete();
                m_cnt = 0;
            end else begin
                check("iready_rule", bus0.iready, !bus0.ovalid || bus0.oready);
                check("iready_rule_s2", bus1.iready, !bus1.ovalid || bus1.oready);
                if (hold_prev) begin
                    check("hold_ovalid", bus0.ovalid, 1);
                    check("hold_result_r", bus0.result_r, prev_r);
                    check("hold_result_i", bus0.result_i, prev_i);
                    check("hold_sat", bus0.sat, prev_s);
                end
                if (bus0.ovalid && bus0.oready) begin
                    n_out++;
                    check("out_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("out_r", bus0.result_r, e.r0);
                        check("out_i", bus0.result_i, e.i0);
                        check("out_sat", bus0.sat, e.s0);
                        check("out_s2_valid", bus1.ovalid, 1);
                        check("out_s2_r", bus1.result_r, e.r2);
                        check("out_s2_i", bus1.result_i, e.i2);
                        check("out_s2_sat", bus1.sat, e.s2);
                    end
                end
                if (reset && bus0.ivalid && bus0.iready) begin
                    model_push(bus0.dataa_r, bus0.dataa_i, bus0.datab_r, bus0.datab_i,
                               bus0.conj_b, int'(bus0.acc_len));
                end
            end
            hold_prev = reset && rst_prev && bus0.ovalid && !bus0.oready;
            prev_r    = bus0.result_r;
            prev_i    = bus0.result_i;
            prev_s    = bus0.sat;
        end
    end

    task automatic drive(input int ar, input int ai, input int br, input int bi,
                         input bit conj, input int len, output int xc);
        bit got;
        got          = 0;
        xc           = -1;
        bus0.dataa_r = 16'(ar);
        bus0.dataa_i = 16'(ai);
        bus0.datab_r = 16'(br);
        bus0.datab_i = 16'(bi);
        bus0.conj_b  = conj;
        bus0.acc_len = 8'(len);
        bus0.ivalid  = 1'b1;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clock);
            got = bus0.iready;
            if (got) xc = cyc;
            @(posedge clock);
            #1;
        end
        check("drive_accept", got, 1);
    endtask

    task automatic idle();
        bus0.ivalid = 1'b0;
    endtask

    task automatic wait_out(input string name, input longint er, input longint ei, input longint es,
                            input longint er2, input longint ei2, input longint es2,
                            input int from, input int lat);
        bit got;
        got = 0;
        for (int k = 0; k < 60 && !got; k++) begin
            @(negedge clock);
            if (bus0.ovalid && bus0.oready) begin
                got = 1;
                check({name, "_r"}, bus0.result_r, er);
                check({name, "_i"}, bus0.result_i, ei);
                check({name, "_sat"}, bus0.sat, es);
                check({name, "_s2_r"}, bus1.result_r, er2);
                check({name, "_s2_i"}, bus1.result_i, ei2);
                check({name, "_s2_sat"}, bus1.sat, es2);
                if (lat >= 0) check({name, "_latency"}, cyc - from, lat);
            end
            @(posedge clock);
            #1;
        end
        check({name, "_seen"}, got, 1);
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 100 && exp_q.size() != 0; k++) begin
            @(posedge clock);
            #1;
        end
        repeat (2) @(posedge clock);
        #1;
        check(name, exp_q.size(), 0);
    endtask

    function automatic int rnd16();
        int v;
        v = int'($urandom_range(65535)) - 32768;
        if ($urandom_range(3) == 0) v = ($urandom_range(1) == 1) ? 32767 : -32768;
        return v;
    endfunction

    initial begin
        int xa, xb, xc, n0;
        reset        = 1'b0;
        bus0.ivalid  = 1'b0;
        bus0.dataa_r = '0;
        bus0.dataa_i = '0;
        bus0.datab_r = '0;
        bus0.datab_i = '0;
        bus0.conj_b  = 1'b0;
        bus0.acc_len = '0;
        bus0.oready  = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;

        drive(3, 4, 1, 2, 0, 1, xc);
        idle();
        wait_out("basic", -5, 10, 0, -1, 3, 0, xc, 5);
        drive(3, 4, 1, 2, 1, 1, xc);
        idle();
        wait_out("conj", 11, -2, 0, 3, 0, 0, xc, 5);
        drive(7, 8, 5, 6, 0, 1, xc);
        idle();
        wait_out("second", -13, 82, 0, -3, 21, 0, xc, 5);
        drive(7, 8, 5, 6, 0, 0, xc);
        idle();
        wait_out("len_zero", -13, 82, 0, -3, 21, 0, xc, 5);

        drive(3, 4, 1, 2, 0, 2, xa);
        drive(7, 8, 5, 6, 0, 2, xb);
        drive(3, 4, 1, 2, 0, 1, xc);
        idle();
        wait_out("frame2", -18, 92, 0, -4, 23, 0, xb, 5);
        wait_out("next_frame", -5, 10, 0, -1, 3, 0, xc, 5);

        drive(-32768, -32768, -32768, -32768, 1, 1, xc);
        idle();
        wait_out("saturate", 2147483647, 0, 1, 536870912, 0, 0, xc, 5);

        n0 = n_out;
        fork
            begin
                for (int k = 0; k < 8; k++) drive(rnd16(), rnd16(), rnd16(), rnd16(), 1'($urandom_range(1)), 1, xc);
                idle();
            end
            begin
                repeat (4) @(posedge clock);
                #1;
                bus0.oready = 1'b0;
                repeat (5) @(posedge clock);
                #1;
                bus0.oready = 1'b1;
            end
        join
        drain("stall_drain");
        check("stall_count", n_out - n0, 8);

        n0 = n_out;
        drive(3, 4, 1, 2, 0, 4, xc);
        drive(7, 8, 5, 6, 0, 4, xc);
        idle();
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        repeat (8) @(posedge clock);
        #1;
        check("rst_discard", n_out - n0, 0);
        for (int k = 0; k < 4; k++) drive(3, 4, 1, 2, 0, 4, xc);
        idle();
        wait_out("after_rst", -20, 40, 0, -5, 10, 0, xc, 5);

        rnd_done = 0;
        fork
            begin
                for (int k = 0; k < 300; k++) begin
                    if ($urandom_range(3) == 0) begin
                        idle();
                        repeat ($urandom_range(1, 3)) @(posedge clock);
                        #1;
                    end
                    drive(rnd16(), rnd16(), rnd16(), rnd16(), 1'($urandom_range(1)), int'($urandom_range(5)), xc);
                end
                idle();
                rnd_done = 1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clock);
                    #1;
                    bus0.oready = ($urandom_range(3) != 0);
                end
                bus0.oready = 1'b1;
            end
        join
        drain("random_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
